bias_bank_loader: RTL

BIAS_BANK_LOADER -- requirements
Module: bias_bank_loader

---
 rtl/bias_pkg.sv | 19 +
 rtl/bias_sat_add.sv | 41 ++++
 rtl/bias_bank_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bias_pkg.sv
// Shared types and constants for the bias bank loader.
// Holds the controller state enum and saturation bound helpers.
package bias_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } bias_state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/bias_sat_add.sv
// Single-lane registered signed adder, clamped to the
// representable range of W bits.
import bias_pkg::*;

module bias_sat_add #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W:0]   sum;
  logic [W-1:0] s_d;
  logic [W-1:0] s_q;

  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    s_d = sum[W-1:0];
    // top two bits disagree only on overflow
    if (sum[W] != sum[W-1]) begin
      s_d = sum[W] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/bias_bank_loader.sv
// Bias bank: streams a full bank in, then serves one group per step.
// Optional saturating bias add is enabled with BIAS_SAT_ADD_EN.
import bias_pkg::*;

module bias_bank_loader #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18,
  parameter int N_GROUPS     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start,
  input  logic                             ld_valid,
  input  logic [DATA_W-1:0]                ld_data,
  output logic                             ld_ready,
  output logic                             load_done,
  input  logic                             grp_next,
  input  logic                             grp_clr,
  output logic [N_adder_tree*DATA_W-1:0]   q,
  output logic                             q_valid,
  output logic [$clog2(N_GROUPS)-1:0]      grp_idx,
  output logic                             grp_wrap
`ifdef BIAS_SAT_ADD_EN
  ,
  input  logic [N_adder_tree*DATA_W-1:0]   acc_in,
  output logic [N_adder_tree*DATA_W-1:0]   sum_out
`endif
);

  localparam int LW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
  localparam int GW = $clog2(N_GROUPS);
  localparam int QW = N_adder_tree * DATA_W;

  localparam logic [LW-1:0] LANE_LAST = LW'(N_adder_tree - 1);
  localparam logic [GW-1:0] GRP_LAST  = GW'(N_GROUPS - 1);

  bias_state_e state_q, state_d;

  logic [LW-1:0] wr_lane_q, wr_lane_d;
  logic [GW-1:0] wr_grp_q, wr_grp_d;
  logic [GW-1:0] grp_idx_q, grp_idx_d;
  logic [QW-1:0] q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          load_done_q, load_done_d;
  logic          grp_wrap_q, grp_wrap_d;

  logic [DATA_W-1:0] mem [N_GROUPS][N_adder_tree];

  logic accept;
  logic last_word;

  assign accept    = (state_q == LOAD) && ld_valid;
  assign last_word = (wr_lane_q == LANE_LAST) && (wr_grp_q == GRP_LAST);

  always_comb begin
    state_d     = state_q;
    wr_lane_d   = wr_lane_q;
    wr_grp_d    = wr_grp_q;
    grp_idx_d   = grp_idx_q;
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    load_done_d = 1'b0;
    grp_wrap_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_lane_d = '0;
          wr_grp_d  = '0;
          q_valid_d = 1'b0;
          grp_idx_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (last_word) begin
            state_d     = SERVE;
            load_done_d = 1'b1;
            wr_lane_d   = '0;
            wr_grp_d    = '0;
          end else if (wr_lane_q == LANE_LAST) begin
            wr_lane_d = '0;
            wr_grp_d  = wr_grp_q + 1'b1;
          end else begin
            wr_lane_d = wr_lane_q + 1'b1;
          end
        end
      end
      SERVE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_lane_d = '0;
          wr_grp_d  = '0;
          q_valid_d = 1'b0;
          grp_idx_d = '0;
        end else begin
          q_valid_d = 1'b1;
          for (int i = 0; i < N_adder_tree; i++) begin
            q_d[i*DATA_W +: DATA_W] = mem[grp_idx_q][i];
          end
          if (grp_clr) begin
            grp_idx_d = '0;
          end else if (grp_next) begin
            if (grp_idx_q == GRP_LAST) begin
              grp_idx_d  = '0;
              grp_wrap_d = 1'b1;
            end else begin
              grp_idx_d = grp_idx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_lane_q   <= '0;
      wr_grp_q    <= '0;
      grp_idx_q   <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      load_done_q <= 1'b0;
      grp_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_lane_q   <= wr_lane_d;
      wr_grp_q    <= wr_grp_d;
      grp_idx_q   <= grp_idx_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      load_done_q <= load_done_d;
      grp_wrap_q  <= grp_wrap_d;
    end
  end

  // storage is fully rewritten before q_valid can rise
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_grp_q][wr_lane_q] <= ld_data;
    end
  end

  assign ld_ready  = (state_q == LOAD);
  assign load_done = load_done_q;
  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign grp_idx   = grp_idx_q;
  assign grp_wrap  = grp_wrap_q;

`ifdef BIAS_SAT_ADD_EN
  for (genvar g = 0; g < N_adder_tree; g++) begin : g_sat
    bias_sat_add #(
      .W(DATA_W)
    ) u_add (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (q_q[g*DATA_W +: DATA_W]),
      .b    (acc_in[g*DATA_W +: DATA_W]),
      .s    (sum_out[g*DATA_W +: DATA_W])
    );
  end
`endif

endmodule
